// File: rtl/router_register_pkg.sv
// Shared router definitions: datapath width, the reserved address code and
// the FSM state encoding that produces the register-stage strobes.
package router_register_pkg;

    localparam int DATA_W = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } router_state_e;

endpackage

// File: rtl/router_register.sv
// Router datapath register stage: captures the header, feeds the FIFO write bus,
// holds one byte across a FIFO-full stall and checks packet parity.
module router_register #(
    parameter int         DATA_W       = router_register_pkg::DATA_W,
    parameter logic [1:0] ADDR_INVALID = router_register_pkg::ADDR_INVALID
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              lfd_state,
    input  logic              rst_int_reg,
    input  logic [DATA_W-1:0] data_in,
    output logic              err,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] int_parity;
    logic [DATA_W-1:0] pkt_parity;

    // resetn is active-high despite its name
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn)
            hdr <= '0;
        else if (detect_add && pkt_valid && data_in[1:0] != ADDR_INVALID)
            hdr <= data_in;
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn)
            dout <= '0;
        else if (lfd_state)
            dout <= hdr;
        else if (ld_state && !fifo_full)
            dout <= data_in;
        else if (laf_state)
            dout <= hold;
    end

    // byte that arrived while the FIFO was full, replayed in LOAD_AFTER_FULL
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn)
            hold <= '0;
        else if (ld_state && fifo_full)
            hold <= data_in;
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn)
            int_parity <= '0;
        else if (detect_add)
            int_parity <= '0;
        else if (lfd_state)
            int_parity <= int_parity ^ hdr;
        else if (ld_state && pkt_valid && !full_state)
            int_parity <= int_parity ^ data_in;
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn)
            pkt_parity <= '0;
        else if (detect_add)
            pkt_parity <= '0;
        else if (ld_state && !fifo_full && !pkt_valid)
            pkt_parity <= data_in;
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn)
            parity_done <= 1'b0;
        else if (detect_add)
            parity_done <= 1'b0;
        else if ((ld_state && !fifo_full && !pkt_valid) ||
                 (laf_state && low_packet_valid && !parity_done))
            parity_done <= 1'b1;
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn)
            low_packet_valid <= 1'b0;
        else if (rst_int_reg)
            low_packet_valid <= 1'b0;
        else if (ld_state && !pkt_valid)
            low_packet_valid <= 1'b1;
    end

    // compared one cycle after parity_done so pkt_parity has settled
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn)
            err <= 1'b0;
        else if (detect_add)
            err <= 1'b0;
        else if (parity_done)
            err <= (int_parity != pkt_parity);
    end

endmodule

// File: tb/tb_router_register.sv
// Directed scoreboard bench for router_register: expected outputs are queued
// as each step is driven and checked once the clock edge has taken effect.
module tb_router_register;

    localparam int W = 8;

    localparam int S_IDLE = 0;
    localparam int S_DA   = 1;
    localparam int S_LFD  = 2;
    localparam int S_LD   = 3;
    localparam int S_FULL = 4;
    localparam int S_LAF  = 5;

    logic         clock = 1'b0;
    logic         resetn;
    logic         pkt_valid, fifo_full, detect_add, ld_state, laf_state;
    logic         full_state, lfd_state, rst_int_reg;
    logic [W-1:0] data_in;
    logic         err, parity_done, low_packet_valid;
    logic [W-1:0] dout;

    typedef struct {
        string        tag;
        logic [W-1:0] dout;
        logic         pd;
        logic         lpv;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    router_register dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .lfd_state(lfd_state), .rst_int_reg(rst_int_reg),
        .data_in(data_in), .err(err), .parity_done(parity_done),
        .low_packet_valid(low_packet_valid), .dout(dout)
    );

    always #5 clock = ~clock;

    task automatic push(input string tag, input logic [W-1:0] d, input logic pd,
                        input logic lpv, input logic e);
        exp_t x;
        x.tag = tag; x.dout = d; x.pd = pd; x.lpv = lpv; x.err = e;
        sb.push_back(x);
    endtask

    task automatic compare_outputs();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty got 0 entries want 1");
            return;
        end
        x = sb.pop_front();
        checks++;
        assert (dout === x.dout) else begin
            failures++;
            $error("FAIL %s.dout got %h want %h", x.tag, dout, x.dout);
        end
        checks++;
        assert (parity_done === x.pd) else begin
            failures++;
            $error("FAIL %s.parity_done got %b want %b", x.tag, parity_done, x.pd);
        end
        checks++;
        assert (low_packet_valid === x.lpv) else begin
            failures++;
            $error("FAIL %s.low_packet_valid got %b want %b", x.tag, low_packet_valid, x.lpv);
        end
        checks++;
        assert (err === x.err) else begin
            failures++;
            $error("FAIL %s.err got %b want %b", x.tag, err, x.err);
        end
    endtask

    // Called at a falling edge: drive one cycle, then check after the rising edge.
    task automatic cyc(input int st, input logic pv, input logic ff, input logic ri,
                       input logic [W-1:0] d, input string tag, input logic [W-1:0] e_dout,
                       input logic e_pd, input logic e_lpv, input logic e_err);
        detect_add  = (st == S_DA);
        lfd_state   = (st == S_LFD);
        ld_state    = (st == S_LD);
        full_state  = (st == S_FULL);
        laf_state   = (st == S_LAF);
        pkt_valid   = pv;
        fifo_full   = ff;
        rst_int_reg = ri;
        data_in     = d;
        push(tag, e_dout, e_pd, e_lpv, e_err);
        @(posedge clock);
        #1;
        compare_outputs();
        @(negedge clock);
    endtask

    initial begin
        resetn = 1'b1;
        {pkt_valid, fifo_full, detect_add, ld_state, laf_state} = '0;
        {full_state, lfd_state, rst_int_reg} = '0;
        data_in = '0;
        @(negedge clock);
        @(negedge clock);
        push("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        compare_outputs();
        resetn = 1'b0;

        // good packet: 0D, 12, 34, 56, parity 7D
        cyc(S_DA,   1, 0, 0, 8'h0D, "good_da",   8'h00, 0, 0, 0);
        cyc(S_LFD,  1, 0, 0, 8'h12, "good_lfd",  8'h0D, 0, 0, 0);
        cyc(S_LD,   1, 0, 0, 8'h12, "good_p0",   8'h12, 0, 0, 0);
        cyc(S_LD,   1, 0, 0, 8'h34, "good_p1",   8'h34, 0, 0, 0);
        cyc(S_LD,   1, 0, 0, 8'h56, "good_p2",   8'h56, 0, 0, 0);
        cyc(S_LD,   0, 0, 0, 8'h7D, "good_par",  8'h7D, 1, 1, 0);
        cyc(S_IDLE, 0, 0, 0, 8'h00, "good_err",  8'h7D, 1, 1, 0);
        cyc(S_IDLE, 0, 0, 1, 8'h00, "rst_int",   8'h7D, 1, 0, 0);

        // bad packet: 0E, A1, 5C, true parity F3, sent 0C
        cyc(S_DA,   1, 0, 0, 8'h0E, "bad_da",    8'h7D, 0, 0, 0);
        cyc(S_LFD,  1, 0, 0, 8'hA1, "bad_lfd",   8'h0E, 0, 0, 0);
        cyc(S_LD,   1, 0, 0, 8'hA1, "bad_p0",    8'hA1, 0, 0, 0);
        cyc(S_LD,   1, 0, 0, 8'h5C, "bad_p1",    8'h5C, 0, 0, 0);
        cyc(S_LD,   0, 0, 0, 8'h0C, "bad_par",   8'h0C, 1, 1, 0);
        cyc(S_IDLE, 0, 0, 0, 8'h00, "bad_err",   8'h0C, 1, 1, 1);
        cyc(S_IDLE, 0, 0, 0, 8'h00, "bad_hold",  8'h0C, 1, 1, 1);
        cyc(S_IDLE, 0, 0, 1, 8'h00, "bad_ri",    8'h0C, 1, 0, 1);

        // invalid address header leaves hdr = 0E; detect_add clears err
        cyc(S_DA,   1, 0, 0, 8'h0F, "inv_da",    8'h0C, 0, 0, 0);
        cyc(S_LFD,  1, 0, 0, 8'h00, "inv_lfd",   8'h0E, 0, 0, 0);

        // FIFO full mid-payload: A5 held and replayed
        cyc(S_LD,   1, 0, 0, 8'h3C, "ff_p0",     8'h3C, 0, 0, 0);
        cyc(S_LD,   1, 1, 0, 8'hA5, "ff_stall",  8'h3C, 0, 0, 0);
        cyc(S_FULL, 1, 1, 0, 8'hA5, "ff_full",   8'h3C, 0, 0, 0);
        cyc(S_LAF,  1, 0, 0, 8'h00, "ff_laf",    8'hA5, 0, 0, 0);
        // parity byte arrives while full: pkt_parity stays 0, laf sets parity_done
        cyc(S_LD,   0, 1, 0, 8'h97, "ffp_stall", 8'hA5, 0, 1, 0);
        cyc(S_FULL, 0, 1, 0, 8'h97, "ffp_full",  8'hA5, 0, 1, 0);
        cyc(S_LAF,  0, 0, 0, 8'h00, "ffp_laf",   8'h97, 1, 1, 0);
        cyc(S_IDLE, 0, 0, 0, 8'h00, "ffp_err",   8'h97, 1, 1, 1);

        // asynchronous reset in the middle of a payload
        cyc(S_DA,   1, 0, 0, 8'h0D, "ar_da",     8'h97, 0, 1, 0);
        cyc(S_LFD,  1, 0, 0, 8'h12, "ar_lfd",    8'h0D, 0, 1, 0);
        cyc(S_LD,   0, 0, 0, 8'h12, "ar_p0",     8'h12, 1, 1, 0);
        {detect_add, lfd_state, ld_state, full_state, laf_state} = '0;
        #2 resetn = 1'b1;
        #1;
        push("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        compare_outputs();
        @(negedge clock);
        resetn = 1'b0;
        // hdr was cleared too: first-data after reset presents 00
        cyc(S_LD,   1, 0, 0, 8'h55, "post_ld",   8'h55, 0, 0, 0);
        cyc(S_LFD,  1, 0, 0, 8'h00, "post_lfd",  8'h00, 0, 0, 0);

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
